cc_rline_serializer: RTL

- Return-path counterpart of the miss-fill deserializer: accepts whole 512-bit cache lines (hit data or freshly filled lines) and emits each one as an 8-beat, 64-bit AXI R burst toward the requesting master.
- Beat order is critical-word-first with wrap-around.
- Sits between the SRAM read pipeline / fill path and the INCT-side R channel.
- Contains a small line FIFO so the SRAM pipeline is not stalled by R-channel backpressure.

---
 rtl/cc_rline_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cc_rline_serializer.sv
// cc_rline_serializer
// Return-path line serializer: buffers whole 512-bit cache lines in a small
// FIFO and emits each as an 8-beat, 64-bit AXI R burst in critical-word-first
// order with wrap-around.
//
// Optional build macro: CC_RLINE_SER_PERF_EN adds perf_lines_o/perf_stall_o.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   line_valid_i        line offered
//   line_ready_o        line accepted on line_valid_i & line_ready_o
//   line_data_i[511:0]  cache line, word 0 at [511:448]
//   line_offset_i[2:0]  critical word index
//   rdata_o[63:0]       R data
//   rvalid_o            R valid
//   rready_i            R ready
//   rlast_o             last beat of burst
//   rresp_o[1:0]        always OKAY
//   perf_lines_o[31:0]  (perf build) completed bursts
//   perf_stall_o[31:0]  (perf build) cycles with rvalid_o & !rready_i
module cc_rline_serializer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         line_valid_i,
  output logic         line_ready_o,
  input  logic [511:0] line_data_i,
  input  logic [2:0]   line_offset_i,
  output logic [63:0]  rdata_o,
  output logic         rvalid_o,
  input  logic         rready_i,
  output logic         rlast_o,
  output logic [1:0]   rresp_o
`ifdef CC_RLINE_SER_PERF_EN
  ,
  output logic [31:0]  perf_lines_o,
  output logic [31:0]  perf_stall_o
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned BEAT_W = 3;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [OFF_W-1:0]  offset;
  } entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // Line storage and control state
  entry_t              mem [DEPTH];
  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                ready_d;
  logic                rvalid_d;
  logic                rlast_d;
  logic [WORD_W-1:0]   rdata_d;

  logic                push;
  logic                beat_fire;
  logic                pop;
  entry_t              head_d;
  logic [BEAT_W-1:0]   word_idx_d;
  logic [8:0]          word_lsb_d;

  assign rresp_o = 2'b00;

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    push       = line_valid_i & line_ready_o;
    beat_fire  = rvalid_o & rready_i;
    pop        = beat_fire & (beat_cnt_q == 3'd7);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    beat_cnt_d = beat_fire ? beat_cnt_q + 3'd1 : beat_cnt_q;

    unique case (state_q)
      S_IDLE: if (push) state_d = S_SEND;
      S_SEND: if (pop && (count_q == CNT_W'(1)) && !push) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A line written into the slot that becomes head is forwarded straight
    // from the input, since the array write lands on the same edge.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d.data   = line_data_i;
      head_d.offset = line_offset_i;
    end else begin
      head_d = mem[rd_ptr_d];
    end

    word_idx_d = head_d.offset + beat_cnt_d;
    word_lsb_d = {3'(3'd7 - word_idx_d), 6'd0};
    rvalid_d   = (state_d == S_SEND);
    rdata_d    = rvalid_d ? head_d.data[word_lsb_d +: WORD_W] : '0;
    rlast_d    = rvalid_d && (beat_cnt_d == 3'd7);
    ready_d    = (count_d != CNT_W'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
      line_ready_o <= 1'b1;
      rvalid_o     <= 1'b0;
      rlast_o      <= 1'b0;
      rdata_o      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
      line_ready_o <= ready_d;
      rvalid_o     <= rvalid_d;
      rlast_o      <= rlast_d;
      rdata_o      <= rdata_d;
    end
  end

  // Line array write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q].data   <= line_data_i;
      mem[wr_ptr_q].offset <= line_offset_i;
    end
  end

`ifdef CC_RLINE_SER_PERF_EN
  // Burst completion and R-channel stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lines_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pop)                  perf_lines_o <= perf_lines_o + 32'd1;
      if (rvalid_o && !rready_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
